imem_axi_lite_master: RTL
=========================

IMEM_AXI_LITE_MASTER -- requirements
Module: imem_axi_lite_master

Interface
REQ-001 Parameters SHALL be exactly:
- ADDR_WIDTH, default 32, address width.
- DATA_WIDTH, default 32, data width.
- WORD_ADDR, default 1; 1 = o_axi_araddr carries the word index (byte address >> 2), 0 = byte address unchanged.

REQ-002 Ports SHALL be exactly (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on its rising edge.
- resetn, in, 1: reset, asynchronous, active-low.
- i_req_valid, in, 1: core fetch request valid.
- i_req_addr, in, ADDR_WIDTH: fetch byte address.
- o_req_ready, out, 1: block can accept a request.
- i_flush, in, 1: discard any pending or future response of the current fetch.
- o_rsp_valid, out, 1: fetched word valid.
- o_rsp_data, out, DATA_WIDTH: fetched word.
- o_rsp_err, out, 1: fetched word carried a non-OKAY response.
- i_rsp_ready, in, 1: core accepts the response.
- o_axi_araddr, out, ADDR_WIDTH: AXI4-Lite AR address.
- o_axi_arvalid, out, 1: AXI4-Lite AR valid.
- i_axi_arready, in, 1: AXI4-Lite AR ready.
- i_axi_rdata, in, DATA_WIDTH: AXI4-Lite R data.
- i_axi_rresp, in, 2: AXI4-Lite R response.
- i_axi_rvalid, in, 1: AXI4-Lite R valid.
- o_axi_rready, out, 1: AXI4-Lite R ready.

Function
REQ-003 All outputs SHALL be registered; at most one AXI read SHALL be outstanding.
REQ-004 FSM states SHALL be IDLE, ADDR, DATA and RESP.
REQ-005 IDLE SHALL hold o_req_ready=1; a request is accepted when i_req_valid & o_req_ready & ~i_flush.
REQ-006 On acceptance the next edge SHALL do all of:
- clear o_req_ready;
- load o_axi_araddr (i_req_addr>>2, zero-extended, when WORD_ADDR=1; otherwise i_req_addr);
- set o_axi_arvalid=1;
- enter ADDR.
REQ-007 In ADDR, o_axi_arvalid and o_axi_araddr SHALL stay stable until i_axi_arready is sampled high. On that edge: o_axi_arvalid<=0, o_axi_rready<=1, enter DATA.
REQ-008 In DATA, o_axi_rready SHALL stay 1 until i_axi_rvalid is sampled high. On that edge:
- o_axi_rready<=0;
- o_rsp_data<=i_axi_rdata;
- o_rsp_err<=(i_axi_rresp!=2'b00);
- o_rsp_valid<=1;
- enter RESP.
REQ-009 In RESP, o_rsp_valid, o_rsp_data and o_rsp_err SHALL hold until i_rsp_ready is sampled high. On that edge: o_rsp_valid<=0, o_req_ready<=1, enter IDLE.
REQ-010 i_axi_rvalid outside DATA and i_axi_arready outside ADDR SHALL be ignored.
REQ-011 Minimum latency SHALL be 3 cycles from request acceptance to o_rsp_valid (arready and rvalid each high on first opportunity).
REQ-012 i_flush sampled high in ADDR or DATA SHALL set an internal drop flag. The AXI transaction SHALL still complete per REQ-007/008. On the R handshake with drop set, o_rsp_valid SHALL stay 0, drop SHALL clear, o_req_ready<=1 and the FSM SHALL enter IDLE.
REQ-013 i_flush sampled high in RESP SHALL clear o_rsp_valid, set o_req_ready and enter IDLE, regardless of i_rsp_ready.
REQ-014 i_flush high in IDLE SHALL block acceptance that cycle and have no other effect; the same-cycle request SHALL NOT be accepted.
REQ-015 o_rsp_data and o_rsp_err SHALL retain their last values when o_rsp_valid=0.

Reset
REQ-016 resetn low SHALL asynchronously force:
- state=IDLE, drop=0;
- o_req_ready, o_axi_arvalid, o_axi_rready, o_rsp_valid, o_rsp_err = 0;
- o_axi_araddr, o_rsp_data = 0.
REQ-017 o_req_ready SHALL rise on the first clock edge after resetn deasserts.
REQ-018 Reset asserted mid-transaction SHALL abandon it without producing a response; the AXI slave is reset by the same resetn.

Verification
REQ-019 Bench SHALL cover:
- Zero-wait fetch: req addr 0x0000_0010 with arready/rvalid immediate, rdata 0x00000013 -> araddr=0x4, rsp_valid 3 cycles after acceptance, data 0x00000013, err 0.
- Stalls: arready delayed 4 cycles, rvalid delayed 3 cycles, i_rsp_ready delayed 2 cycles -> arvalid/araddr stable throughout; rsp held stable until i_rsp_ready.
- Error: rresp=2'b10 with rdata 0xDEADBEEF -> rsp_err=1, rsp_data=0xDEADBEEF.
- Flush in DATA: i_flush pulsed while waiting for rvalid -> R beat accepted (rready=1 at rvalid), no rsp_valid, o_req_ready=1 the cycle after the beat. Flush+req same cycle in IDLE -> request not accepted.
- Reset mid-ADDR: resetn low while arvalid=1 -> all outputs 0 immediately; o_req_ready=1 one edge after release; a new fetch of 0x20 completes with araddr=0x8.

Source files
------------

// File: rtl/imem_axi_lite_master.sv
// Instruction-fetch AXI4-Lite read master: one outstanding read, every output registered.
// A flush discards the in-flight read's response (the AXI beat is still consumed) or the held response.
module imem_axi_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WORD_ADDR  = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  o_req_ready,
  input  logic                  i_flush,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_err,
  input  logic                  i_rsp_ready,
  output logic [ADDR_WIDTH-1:0] o_axi_araddr,
  output logic                  o_axi_arvalid,
  input  logic                  i_axi_arready,
  input  logic [DATA_WIDTH-1:0] i_axi_rdata,
  input  logic [1:0]            i_axi_rresp,
  input  logic                  i_axi_rvalid,
  output logic                  o_axi_rready
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e                state_q, state_d;
  logic                  drop_q, drop_d;
  logic                  req_ready_q, req_ready_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  accept;

  // Acceptance uses the registered ready, so ready only rises one edge after reset releases.
  assign accept = i_req_valid & req_ready_q & ~i_flush;

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    req_ready_d = req_ready_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          araddr_d    = (WORD_ADDR != 0) ? (i_req_addr >> 2) : i_req_addr;
          arvalid_d   = 1'b1;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        if (i_flush) drop_d = 1'b1;
        if (i_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (i_flush) drop_d = 1'b1;
        if (i_axi_rvalid) begin
          rready_d = 1'b0;
          // A flush on the beat itself also discards it; data/err keep their old values.
          if (drop_q | i_flush) begin
            drop_d      = 1'b0;
            req_ready_d = 1'b1;
            state_d     = IDLE;
          end else begin
            rsp_data_d  = i_axi_rdata;
            rsp_err_d   = |i_axi_rresp;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end
      RESP: begin
        if (i_flush | i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      req_ready_q <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      req_ready_q <= req_ready_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_req_ready   = req_ready_q;
  assign o_axi_araddr  = araddr_q;
  assign o_axi_arvalid = arvalid_q;
  assign o_axi_rready  = rready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_err     = rsp_err_q;
endmodule
